// File: rtl/kb_key_sequencer.sv
// PS/2 set-2 key sequencer: prefix parsing, shift/capslock tracking, converter handshake, ASCII FIFO.
// Optional build macro KB_TYPEMATIC_FILTER_EN suppresses repeated makes of the same key.
module kb_key_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_scancode,
    input  logic       i_scancode_valid,
    output logic [7:0] o_conv_scancode,
    output logic       o_conv_shift,
    output logic       o_conv_capslock,
    input  logic [7:0] i_conv_ascii,
    output logic [7:0] o_ascii,
    output logic       o_ascii_valid,
    input  logic       i_ascii_ready,
    output logic       o_capslock_led,
    output logic       o_overflow
);

    typedef enum logic [1:0] {StIdle, StBreak, StExt, StExtBreak} state_e;

    localparam logic [FIFO_AW:0]   CountFull = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CountOne  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PtrOne    = FIFO_AW'(1);

    state_e state_q, state_d;

    logic       lshift_q, rshift_q, caps_q, caps_held_q, conv_pending_q;
    logic [7:0] conv_scancode_q;
    logic       overflow_q;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;

    // Decoded per-byte actions
    logic set_lshift, clr_lshift, set_rshift, clr_rshift;
    logic caps_press, clr_caps_held, make_seen, break_seen, latch_code;

    logic push_req, fifo_full, do_push, do_pop;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (i_scancode_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (i_scancode == 8'hF0)      state_d = StBreak;
                    else if (i_scancode == 8'hE0) state_d = StExt;
                end
                StBreak:    state_d = StIdle;
                StExt:      state_d = (i_scancode == 8'hF0) ? StExtBreak : StIdle;
                StExtBreak: state_d = StIdle;
                default:    state_d = StIdle;
            endcase
        end
    end

    // ---------------- FSM: action decode ----------------
    always_comb begin
        set_lshift    = 1'b0;
        clr_lshift    = 1'b0;
        set_rshift    = 1'b0;
        clr_rshift    = 1'b0;
        caps_press    = 1'b0;
        clr_caps_held = 1'b0;
        make_seen     = 1'b0;
        break_seen    = 1'b0;
        if (i_scancode_valid) begin
            unique case (state_q)
                StIdle: begin
                    case (i_scancode)
                        8'h12:        set_lshift = 1'b1;
                        8'h59:        set_rshift = 1'b1;
                        8'h58:        caps_press = 1'b1;
                        8'hF0, 8'hE0: ;
                        default:      make_seen  = 1'b1;
                    endcase
                end
                StBreak: begin
                    break_seen = 1'b1;
                    case (i_scancode)
                        8'h12:   clr_lshift    = 1'b1;
                        8'h59:   clr_rshift    = 1'b1;
                        8'h58:   clr_caps_held = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

`ifdef KB_TYPEMATIC_FILTER_EN
    logic [7:0] last_make_q;

    assign latch_code = make_seen && (i_scancode != last_make_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_make_q <= 8'h00;
        end else if (latch_code) begin
            last_make_q <= i_scancode;
        end else if (break_seen && (i_scancode == last_make_q)) begin
            last_make_q <= 8'h00;
        end
    end
`else
    assign latch_code = make_seen;
`endif

    // ---------------- Modifiers and converter latch ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lshift_q        <= 1'b0;
            rshift_q        <= 1'b0;
            caps_q          <= 1'b0;
            caps_held_q     <= 1'b0;
            conv_pending_q  <= 1'b0;
            conv_scancode_q <= 8'h00;
        end else begin
            if (set_lshift)      lshift_q <= 1'b1;
            else if (clr_lshift) lshift_q <= 1'b0;
            if (set_rshift)      rshift_q <= 1'b1;
            else if (clr_rshift) rshift_q <= 1'b0;
            // Only the first 58 of a held key toggles; typematic repeats are swallowed
            if (caps_press && !caps_held_q) begin
                caps_q      <= ~caps_q;
                caps_held_q <= 1'b1;
            end else if (clr_caps_held) begin
                caps_held_q <= 1'b0;
            end
            conv_pending_q <= latch_code;
            if (latch_code) conv_scancode_q <= i_scancode;
        end
    end

    // ---------------- ASCII FIFO ----------------
    assign push_req  = conv_pending_q && (i_conv_ascii != 8'hFF);
    assign fifo_full = (count_q == CountFull);
    assign do_pop    = o_ascii_valid && i_ascii_ready;
    assign do_push   = push_req && (!fifo_full || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)      count_d = count_q + CountOne;
        else if (!do_push && do_pop) count_d = count_q - CountOne;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
            count_q <= count_d;
            if (push_req && fifo_full && !do_pop) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty
    always_ff @(posedge i_clk) begin
        if (do_push) fifo_mem[wr_ptr_q] <= i_conv_ascii;
    end

    // ---------------- Outputs ----------------
    assign o_conv_scancode = conv_scancode_q;
    assign o_conv_shift    = lshift_q | rshift_q;
    assign o_conv_capslock = caps_q;
    assign o_capslock_led  = caps_q;
    assign o_ascii_valid   = (count_q != '0);
    assign o_ascii         = o_ascii_valid ? fifo_mem[rd_ptr_q] : 8'h00;
    assign o_overflow      = overflow_q;

endmodule

// File: tb/tb_kb_key_sequencer.sv
// Directed self-checking bench for kb_key_sequencer with a small letter-only converter model.
module tb_kb_key_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] scancode = 8'h00;
    logic       scancode_valid = 1'b0;
    logic [7:0] conv_scancode;
    logic       conv_shift, conv_capslock;
    logic [7:0] conv_ascii;
    logic [7:0] ascii;
    logic       ascii_valid;
    logic       ascii_ready = 1'b0;
    logic       capslock_led, overflow;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    kb_key_sequencer #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_scancode       (scancode),
        .i_scancode_valid (scancode_valid),
        .o_conv_scancode  (conv_scancode),
        .o_conv_shift     (conv_shift),
        .o_conv_capslock  (conv_capslock),
        .i_conv_ascii     (conv_ascii),
        .o_ascii          (ascii),
        .o_ascii_valid    (ascii_valid),
        .i_ascii_ready    (ascii_ready),
        .o_capslock_led   (capslock_led),
        .o_overflow       (overflow)
    );

    // Converter: a..e only, uppercase when shift XOR capslock, FF otherwise
    function automatic logic [7:0] conv(input logic [7:0] sc, input logic sh, input logic cp);
        logic [7:0] base;
        case (sc)
            8'h1C:   base = 8'h61;
            8'h32:   base = 8'h62;
            8'h21:   base = 8'h63;
            8'h23:   base = 8'h64;
            8'h24:   base = 8'h65;
            default: return 8'hFF;
        endcase
        return (sh ^ cp) ? base - 8'h20 : base;
    endfunction

    assign conv_ascii = conv(conv_scancode, conv_shift, conv_capslock);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // Presents one byte for exactly one rising edge; returns on the following falling edge
    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        scancode       = b;
        scancode_valid = 1'b1;
        @(negedge clk);
        scancode_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        @(negedge clk);
        chk({tag, "_valid"}, {7'b0, ascii_valid}, 8'h01);
        chk(tag, ascii, exp);
        ascii_ready = 1'b1;
        @(negedge clk);
        ascii_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // Reset values while reset is held
        #3;
        chk("rst_valid", {7'b0, ascii_valid}, 8'h00);
        chk("rst_ascii", ascii, 8'h00);
        chk("rst_conv_sc", conv_scancode, 8'h00);
        chk("rst_shift", {7'b0, conv_shift}, 8'h00);
        chk("rst_caps", {7'b0, conv_capslock}, 8'h00);
        chk("rst_led", {7'b0, capslock_led}, 8'h00);
        chk("rst_ovf", {7'b0, overflow}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Single make: visible exactly two cycles after the strobe, popped the next
        ascii_ready = 1'b1;
        strobe(8'h1C);
        chk("lat_n1_valid", {7'b0, ascii_valid}, 8'h00);
        chk("lat_conv_sc", conv_scancode, 8'h1C);
        @(negedge clk);
        chk("lat_n2_valid", {7'b0, ascii_valid}, 8'h01);
        chk("lat_n2_ascii", ascii, 8'h61);
        @(negedge clk);
        chk("lat_popped", {7'b0, ascii_valid}, 8'h00);
        ascii_ready = 1'b0;

        // Shift press/release around a make
        strobe(8'h12);
        chk("shift_on", {7'b0, conv_shift}, 8'h01);
        strobe(8'h1C);
        strobe(8'hF0);
        strobe(8'h1C);
        chk("shift_held", {7'b0, conv_shift}, 8'h01);
        strobe(8'hF0);
        strobe(8'h12);
        chk("shift_off", {7'b0, conv_shift}, 8'h00);
        strobe(8'h1C);
        pop_expect("shift_A", 8'h41);
        pop_expect("shift_a", 8'h61);
        chk("shift_empty", {7'b0, ascii_valid}, 8'h00);

        // Capslock toggles once per press despite typematic repeat
        strobe(8'h58);
        chk("caps_led1", {7'b0, capslock_led}, 8'h01);
        strobe(8'h58);
        chk("caps_rep", {7'b0, capslock_led}, 8'h01);
        strobe(8'hF0);
        strobe(8'h58);
        chk("caps_flag", {7'b0, conv_capslock}, 8'h01);
        strobe(8'h1C);
        pop_expect("caps_A", 8'h41);
        strobe(8'h58);
        strobe(8'hF0);
        strobe(8'h58);
        chk("caps_led0", {7'b0, capslock_led}, 8'h00);

        // Extended codes, fake shift and undefined codes queue nothing
        strobe(8'hE0);
        strobe(8'h75);
        strobe(8'hE0);
        strobe(8'hF0);
        strobe(8'h75);
        strobe(8'hE0);
        strobe(8'h12);
        chk("ext_noshift", {7'b0, conv_shift}, 8'h00);
        strobe(8'h05);
        idle(2);
        chk("ext_empty", {7'b0, ascii_valid}, 8'h00);
        chk("ext_noovf", {7'b0, overflow}, 8'h00);
        // Back in IDLE: a plain make is converted
        strobe(8'h32);
        pop_expect("ext_idle_b", 8'h62);

        // Overflow: five makes into a 4-deep FIFO with no consumer
        strobe(8'h1C);
        strobe(8'h32);
        strobe(8'h21);
        strobe(8'h23);
        chk("ovf_before", {7'b0, overflow}, 8'h00);
        strobe(8'h24);
        @(negedge clk);
        chk("ovf_set", {7'b0, overflow}, 8'h01);
        chk("ovf_head", ascii, 8'h61);
        // Push and pop in the same cycle while full
        scancode       = 8'h1C;
        scancode_valid = 1'b1;
        @(negedge clk);
        scancode_valid = 1'b0;
        ascii_ready    = 1'b1;
        @(negedge clk);
        ascii_ready = 1'b0;
        chk("ovf_sticky", {7'b0, overflow}, 8'h01);
        pop_expect("ovf_b", 8'h62);
        pop_expect("ovf_c", 8'h63);
        pop_expect("ovf_d", 8'h64);
        pop_expect("ovf_a", 8'h61);
        chk("ovf_empty", {7'b0, ascii_valid}, 8'h00);

        // Asynchronous reset in the middle of a break sequence with entries queued
        strobe(8'h58);
        strobe(8'hF0);
        strobe(8'h58);
        strobe(8'h12);
        strobe(8'h1C);
        strobe(8'h32);
        strobe(8'h21);
        strobe(8'hF0);
        chk("pre_rst_head", ascii, 8'h61);
        chk("pre_rst_led", {7'b0, capslock_led}, 8'h01);
        chk("pre_rst_shift", {7'b0, conv_shift}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {7'b0, ascii_valid}, 8'h00);
        chk("mid_rst_ascii", ascii, 8'h00);
        chk("mid_rst_led", {7'b0, capslock_led}, 8'h00);
        chk("mid_rst_shift", {7'b0, conv_shift}, 8'h00);
        chk("mid_rst_ovf", {7'b0, overflow}, 8'h00);
        chk("mid_rst_sc", conv_scancode, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        strobe(8'h1C);
        pop_expect("post_rst_a", 8'h61);
        chk("post_rst_empty", {7'b0, ascii_valid}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
